bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Reads the BCD digit outputs of a chain of decade counters and drives a
//   multiplexed common-anode 7-segment display. One digit is lit per scan slot.
//   Digits are snapshotted once per frame so a count changing mid-scan never tears.
//   Sits between the counter chain and the board display pins.
// PARAMETERS
//   NUM_DIGITS    4       digits scanned; digit 0 = least significant
//   REFRESH_DIV   100000  clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  1000    anti-ghost cycles at slot start, all anodes off (< REFRESH_DIV)
//   ACTIVE_LOW    1       1: seg/dp/an pins active-low; 0: active-high
// PORTS
//   clock         in   1             system clock, rising edge
//   reset         in   1             asynchronous, active-high
//   digits        in   4*NUM_DIGITS  BCD digits; digit i = digits[4i+3:4i]
//   blank_leading in   1             1: suppress leading zeros
//   dp_mask       in   NUM_DIGITS    decimal point request per digit
//   seg           out  7             {g,f,e,d,c,b,a}
//   dp            out  1             decimal point
//   an            out  NUM_DIGITS    one-hot anode enable
//   frame_start   out  1             1-cycle pulse when the snapshot is taken
// BEHAVIOUR
//   - Reset (async): prescaler=0, slot index=0, snapshot=0, frame_start=0;
//     seg, dp, an all driven to inactive level (all 1s if ACTIVE_LOW).
//   - Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, index advances
//     0..NUM_DIGITS-1 and wraps to 0.
//   - Snapshot: when index goes NUM_DIGITS-1 -> 0 (and on the first cycle out
//     of reset), digits/dp_mask/blank_leading are latched; frame_start pulses
//     that cycle. Input changes at other times are ignored until next frame.
//   - Decode (internal active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//     8:7F 9:6F; codes 10-15 show dash 40 (segment g only).
//   - Leading-zero blank: digit i (i>0) is blank if latched blank_leading=1,
//     digit i=0, and all digits above i are 0. Digit 0 is never blanked.
//     Blank digit: its anode stays off, seg/dp inactive.
//   - Slot timing: prescaler < BLANK_CYCLES -> all anodes off, seg/dp inactive;
//     otherwise an[index] active and seg/dp = decoded latched digit[index].
//   - All outputs registered: pins reflect prescaler/index state with exactly
//     1 cycle latency. At most one anode active in any cycle, never a glitch
//     across slot boundaries.
//   - ACTIVE_LOW inverts seg, dp and an at the output register only.
//   - Reset asserted mid-slot: outputs go inactive immediately (async); scan
//     restarts at digit 0 with a fresh snapshot after release.
// TESTING (bench uses NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1)
//   1. Reset, digits=16'h1234 -> an=1111 during reset; per slot an cycles
//      1110,1101,1011,0111 with seg=~06-style codes 4,3,2,1 (~66,~4F,~5B,~06).
//   2. Each slot: first cycle an=1111, next 3 cycles one anode low; period
//      16 cycles; frame_start once per 16 cycles.
//   3. Change digits 16'h1234->16'h5678 mid-frame -> remainder of frame still
//      shows 1234; 5678 from next frame_start.
//   4. blank_leading=1, digits=16'h0050 -> digit3,2 anodes never active;
//      digit1 shows 5, digit0 shows 0. digits=0 -> only digit0 lit with 0.
//   5. digits=16'h00AF, dp_mask=4'b0001 -> digits 0/1 seg=~40 (dash);
//      dp low only during digit0 slot.
//   6. Assert reset in mid-slot -> an/seg/dp all 1s same cycle; after release,
//      first lit slot is digit0 with freshly latched value.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode 7-segment scanner for a chain of BCD decade counters.
// Digits are snapshotted once per frame; all pins are registered with one cycle of latency.
module bcd_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    blank_leading,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    prime_q;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic                    bl_q, bl_d;
    logic                    fs_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;

    logic                    slot_end, frame_end, take_snap;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    zero_above, dig_zero;
    logic [3:0]              cur_dig;
    logic                    lit;
    logic [6:0]              seg_act;
    logic                    dp_act;
    logic [NUM_DIGITS-1:0]   an_act;

    // prime_q marks the first cycle out of reset: the scan holds at slot 0 for
    // that cycle so the fresh snapshot lines up with frame_start like any other frame.
    always_comb begin
        slot_end  = (presc_q == PRESC_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        take_snap = prime_q || frame_end;
        presc_d   = presc_q;
        idx_d     = idx_q;
        if (!prime_q) begin
            presc_d = slot_end ? '0 : presc_q + 1'b1;
            if (slot_end)
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        dig_d = take_snap ? digits        : dig_q;
        dpm_d = take_snap ? dp_mask       : dpm_q;
        bl_d  = take_snap ? blank_leading : bl_q;
    end

    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        dig_zero   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            dig_zero     = (dig_q[4*i +: 4] == 4'd0);
            blank_vec[i] = bl_q && zero_above && dig_zero;
            zero_above   = zero_above && dig_zero;
        end
    end

    always_comb begin
        cur_dig = dig_q[4*int'(idx_q) +: 4];
        lit     = !prime_q && (presc_q >= BLANK_END) && !blank_vec[idx_q];
        case (cur_dig)
            4'd0:    seg_act = 7'h3F;
            4'd1:    seg_act = 7'h06;
            4'd2:    seg_act = 7'h5B;
            4'd3:    seg_act = 7'h4F;
            4'd4:    seg_act = 7'h66;
            4'd5:    seg_act = 7'h6D;
            4'd6:    seg_act = 7'h7D;
            4'd7:    seg_act = 7'h07;
            4'd8:    seg_act = 7'h7F;
            4'd9:    seg_act = 7'h6F;
            default: seg_act = 7'h40;
        endcase
        if (!lit)
            seg_act = 7'h00;
        dp_act = lit && dpm_q[idx_q];
        an_act = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            prime_q <= 1'b1;
            dig_q   <= '0;
            dpm_q   <= '0;
            bl_q    <= 1'b0;
            fs_q    <= 1'b0;
            seg_q   <= {7{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
            an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            prime_q <= 1'b0;
            dig_q   <= dig_d;
            dpm_q   <= dpm_d;
            bl_q    <= bl_d;
            fs_q    <= take_snap;
            seg_q   <= seg_act ^ {7{ACTIVE_LOW}};
            dp_q    <= dp_act ^ ACTIVE_LOW;
            an_q    <= an_act ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: 4 digits, 4-cycle slots, 1 blank cycle, active-low pins.
module tb_bcd_display_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic        blank_leading = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int waited;

    always #5 clock = ~clock;

    bcd_display_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .digits       (digits),
        .blank_leading(blank_leading),
        .dp_mask      (dp_mask),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .frame_start  (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Steps at least one cycle, then stops on the next frame_start (bounded).
    task automatic wait_frame(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!frame_start && cycles < 40);
        if (!frame_start)
            check({tag, " frame_timeout"}, frame_start, 1);
    endtask

    // Checks the 16 cycles after a frame_start. Tables hold active-low pin
    // levels for the lit cycles of slots 3..0; the first cycle of each slot is dark.
    task automatic expect_frame(input string tag, input logic [15:0] an_t,
                                input logic [27:0] seg_t, input logic [3:0] dp_t,
                                input logic [15:0] new_dig, input int change_at);
        int s;
        logic on;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            s  = k / 4;
            on = (k % 4) != 0;
            check($sformatf("%s an k%0d", tag, k),  an,  on ? an_t[4*s +: 4]  : 4'hF);
            check($sformatf("%s seg k%0d", tag, k), seg, on ? seg_t[7*s +: 7] : 7'h7F);
            check($sformatf("%s dp k%0d", tag, k),  dp,  on ? dp_t[s]         : 1'b1);
            check($sformatf("%s fs k%0d", tag, k),  frame_start, (k == 15));
            if (k == change_at)
                digits = new_dig;
        end
    endtask

    task automatic show(input string tag, input logic [15:0] dig, input logic [3:0] mask,
                        input logic bl, input logic [15:0] an_t, input logic [27:0] seg_t,
                        input logic [3:0] dp_t);
        int cyc;
        digits        = dig;
        dp_mask       = mask;
        blank_leading = bl;
        wait_frame(tag, cyc);
        check({tag, " period"}, cyc, 16);
        expect_frame(tag, an_t, seg_t, dp_t, dig, 99);
    endtask

    initial begin
        digits = 16'h1234;
        repeat (3) @(negedge clock);
        check("rst an", an, 4'hF);
        check("rst seg", seg, 7'h7F);
        check("rst dp", dp, 1'b1);
        check("rst fs", frame_start, 1'b0);
        reset = 1'b0;

        wait_frame("boot", waited);
        check("boot fs_latency", waited, 1);
        // 1234 shown; switching to 5678 mid-frame must not tear the frame.
        expect_frame("d1234", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19},
                     4'hF, 16'h5678, 6);
        expect_frame("d5678", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h12, 7'h02, 7'h78, 7'h00},
                     4'hF, 16'h5678, 99);

        show("lz0050", 16'h0050, 4'b0000, 1'b1,
             {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
        show("lz0000", 16'h0000, 4'b0000, 1'b1,
             {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        show("lz1005", 16'h1005, 4'b0000, 1'b1,
             {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h40, 7'h40, 7'h12}, 4'hF);
        show("dash00af", 16'h00AF, 4'b0001, 1'b0,
             {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h3F, 7'h3F}, 4'b1110);

        // Reset in the middle of a lit slot, then restart with new inputs.
        repeat (6) @(negedge clock);
        check("pre_rst an", an, 4'hD);
        reset = 1'b1;
        #1;
        check("midrst an", an, 4'hF);
        check("midrst seg", seg, 7'h7F);
        check("midrst dp", dp, 1'b1);
        check("midrst fs", frame_start, 1'b0);
        digits        = 16'h2090;
        dp_mask       = 4'b0100;
        blank_leading = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wait_frame("reboot", waited);
        check("reboot fs_latency", waited, 1);
        expect_frame("d2090", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h24, 7'h40, 7'h10, 7'h40},
                     4'b1011, 16'h2090, 99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
